// File: rtl/tlul_txn_monitor_if.sv
// TL-UL A/D channel bundle as seen by a passive monitor.
// master drives every field (DUT-port side); slave only observes.
interface tlul_txn_monitor_if #(
  parameter int SrcWidth = 8
);
  logic                a_valid_i;
  logic                a_ready_i;
  logic [2:0]          a_opcode_i;
  logic [SrcWidth-1:0] a_source_i;
  logic [31:0]         a_address_i;
  logic                d_valid_i;
  logic                d_ready_i;
  logic [2:0]          d_opcode_i;
  logic [SrcWidth-1:0] d_source_i;
  logic                d_error_i;

  modport master (
    output a_valid_i, a_ready_i, a_opcode_i, a_source_i, a_address_i,
    output d_valid_i, d_ready_i, d_opcode_i, d_source_i, d_error_i
  );

  modport slave (
    input a_valid_i, a_ready_i, a_opcode_i, a_source_i, a_address_i,
    input d_valid_i, d_ready_i, d_opcode_i, d_source_i, d_error_i
  );
endinterface

// File: rtl/tlul_txn_monitor.sv
// Passive TL-UL monitor: tracks in-flight sources, counts Get/Put/D-error traffic,
// latches the first protocol violation. All outputs registered, one cycle after the handshake.
module tlul_txn_monitor #(
  parameter int SrcWidth       = 8,
  parameter int MaxOutstanding = 4,
  parameter int CntWidth       = 32,
  parameter int TimeoutCycles  = 1024,
  localparam int OutW          = $clog2(MaxOutstanding + 1)
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  tlul_txn_monitor_if.slave   tl,
  output logic [OutW-1:0]     outstanding_o,
  output logic [CntWidth-1:0] get_cnt_o,
  output logic [CntWidth-1:0] put_cnt_o,
  output logic [CntWidth-1:0] derr_cnt_o,
  output logic                err_o,
  output logic [2:0]          err_code_o,
  output logic                idle_o
);
  localparam int AgeW = $clog2(TimeoutCycles + 1);
  localparam logic [AgeW-1:0] AgeMax = AgeW'(TimeoutCycles);

  typedef struct packed {
    logic                vld;
    logic [SrcWidth-1:0] src;
    logic                exp_op;
    logic [AgeW-1:0]     age;
  } entry_t;

  entry_t tbl_q [MaxOutstanding];
  entry_t tbl_d [MaxOutstanding];

  logic                sh_vld_q, sh_vld_d;
  logic [2:0]          sh_op_q, sh_op_d;
  logic [SrcWidth-1:0] sh_src_q, sh_src_d;
  logic [31:0]         sh_addr_q, sh_addr_d;

  logic [OutW-1:0]     out_q, out_d;
  logic [CntWidth-1:0] get_q, get_d, put_q, put_d, derr_q, derr_d;
  logic                err_q, err_d;
  logic [2:0]          code_q, code_d;

  logic a_hs, d_hs, d_hit, alloc_done, dup, full;
  logic e_badop, e_dup, e_ovf, e_unexp, e_rspop, e_unstable, e_tmo;

  always_comb begin
    for (int i = 0; i < MaxOutstanding; i++) tbl_d[i] = tbl_q[i];
    get_d      = get_q;
    put_d      = put_q;
    derr_d     = derr_q;
    err_d      = err_q;
    code_d     = code_q;
    out_d      = '0;
    d_hit      = 1'b0;
    alloc_done = 1'b0;
    dup        = 1'b0;
    full       = 1'b1;
    e_badop    = 1'b0;
    e_dup      = 1'b0;
    e_ovf      = 1'b0;
    e_rspop    = 1'b0;
    e_tmo      = 1'b0;
    a_hs       = tl.a_valid_i & tl.a_ready_i;
    d_hs       = tl.d_valid_i & tl.d_ready_i;

    // D is resolved first so the same-cycle A can reuse the freed slot/source.
    for (int i = 0; i < MaxOutstanding; i++) begin
      if (d_hs && !d_hit && tbl_q[i].vld && tbl_q[i].src == tl.d_source_i) begin
        d_hit        = 1'b1;
        e_rspop      = (tl.d_opcode_i != {2'b00, tbl_q[i].exp_op});
        tbl_d[i].vld = 1'b0;
      end
    end
    e_unexp = d_hs & ~d_hit;
    if (d_hs && tl.d_error_i && derr_q != '1) derr_d = derr_q + CntWidth'(1);

    for (int i = 0; i < MaxOutstanding; i++) begin
      if (tbl_d[i].vld && tbl_q[i].age != AgeMax) begin
        tbl_d[i].age = tbl_q[i].age + AgeW'(1);
        if (tbl_q[i].age == AgeMax - AgeW'(1)) e_tmo = 1'b1;
      end
    end

    for (int i = 0; i < MaxOutstanding; i++) begin
      if (tbl_d[i].vld && tbl_d[i].src == tl.a_source_i) dup = 1'b1;
      if (!tbl_d[i].vld) full = 1'b0;
    end

    if (a_hs) begin
      if (!(tl.a_opcode_i inside {3'd0, 3'd1, 3'd4})) e_badop = 1'b1;
      else if (dup)  e_dup = 1'b1;
      else if (full) e_ovf = 1'b1;
      else begin
        for (int i = 0; i < MaxOutstanding; i++) begin
          if (!alloc_done && !tbl_d[i].vld) begin
            alloc_done = 1'b1;
            tbl_d[i]   = '{vld: 1'b1, src: tl.a_source_i,
                           exp_op: (tl.a_opcode_i == 3'd4), age: '0};
          end
        end
        if (tl.a_opcode_i == 3'd4) begin
          if (get_q != '1) get_d = get_q + CntWidth'(1);
        end else if (put_q != '1) begin
          put_d = put_q + CntWidth'(1);
        end
      end
    end

    e_unstable = sh_vld_q & (~tl.a_valid_i | (tl.a_opcode_i != sh_op_q) |
                 (tl.a_source_i != sh_src_q) | (tl.a_address_i != sh_addr_q));

    if (!err_q) begin
      err_d = 1'b1;
      if (e_badop)         code_d = 3'd1;
      else if (e_dup)      code_d = 3'd2;
      else if (e_ovf)      code_d = 3'd3;
      else if (e_unexp)    code_d = 3'd4;
      else if (e_rspop)    code_d = 3'd5;
      else if (e_unstable) code_d = 3'd6;
      else if (e_tmo)      code_d = 3'd7;
      else                 err_d  = 1'b0;
    end

    for (int i = 0; i < MaxOutstanding; i++) out_d = out_d + OutW'(tbl_d[i].vld);

    sh_vld_d  = tl.a_valid_i & ~tl.a_ready_i;
    sh_op_d   = tl.a_opcode_i;
    sh_src_d  = tl.a_source_i;
    sh_addr_d = tl.a_address_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < MaxOutstanding; i++) tbl_q[i] <= '0;
      sh_vld_q  <= 1'b0;
      sh_op_q   <= '0;
      sh_src_q  <= '0;
      sh_addr_q <= '0;
      out_q     <= '0;
      get_q     <= '0;
      put_q     <= '0;
      derr_q    <= '0;
      err_q     <= 1'b0;
      code_q    <= '0;
    end else begin
      for (int i = 0; i < MaxOutstanding; i++) tbl_q[i] <= tbl_d[i];
      sh_vld_q  <= sh_vld_d;
      sh_op_q   <= sh_op_d;
      sh_src_q  <= sh_src_d;
      sh_addr_q <= sh_addr_d;
      out_q     <= out_d;
      get_q     <= get_d;
      put_q     <= put_d;
      derr_q    <= derr_d;
      err_q     <= err_d;
      code_q    <= code_d;
    end
  end

  assign outstanding_o = out_q;
  assign get_cnt_o     = get_q;
  assign put_cnt_o     = put_q;
  assign derr_cnt_o    = derr_q;
  assign err_o         = err_q;
  assign err_code_o    = code_q;
  assign idle_o        = (out_q == '0);
endmodule

// File: tb/tb_tlul_txn_monitor.sv
// Directed bench for tlul_txn_monitor (MaxOutstanding=4, TimeoutCycles=8, CntWidth=3).
module tb_tlul_txn_monitor;
  localparam int SW = 8;
  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [2:0]    outstanding;
  logic [CW-1:0] get_cnt, put_cnt, derr_cnt;
  logic          err;
  logic [2:0]    err_code;
  logic          idle;
  int            pass_cnt = 0;
  int            total_cnt = 0;

  always #5 clk = ~clk;

  tlul_txn_monitor_if #(.SrcWidth(SW)) tl ();

  tlul_txn_monitor #(
    .SrcWidth(SW), .MaxOutstanding(4), .CntWidth(CW), .TimeoutCycles(8)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .tl(tl.slave),
    .outstanding_o(outstanding), .get_cnt_o(get_cnt), .put_cnt_o(put_cnt),
    .derr_cnt_o(derr_cnt), .err_o(err), .err_code_o(err_code), .idle_o(idle)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_idle();
    tl.a_valid_i = 0; tl.a_ready_i = 0; tl.a_opcode_i = 0; tl.a_source_i = 0;
    tl.a_address_i = 0; tl.d_valid_i = 0; tl.d_ready_i = 0; tl.d_opcode_i = 0;
    tl.d_source_i = 0; tl.d_error_i = 0;
  endtask

  task automatic drive_a(input logic [2:0] op, input logic [SW-1:0] src);
    tl.a_valid_i = 1; tl.a_ready_i = 1; tl.a_opcode_i = op; tl.a_source_i = src;
  endtask

  task automatic drive_d(input logic [2:0] op, input logic [SW-1:0] src, input logic e);
    tl.d_valid_i = 1; tl.d_ready_i = 1; tl.d_opcode_i = op; tl.d_source_i = src;
    tl.d_error_i = e;
  endtask

  task automatic do_reset();
    bus_idle();
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
  endtask

  task automatic test_reset();
    do_reset();
    total_cnt++; if ({outstanding, get_cnt, put_cnt, derr_cnt, err, err_code} !== '0)
      $display("FAIL reset_zero got %0h want 0", {outstanding, get_cnt, put_cnt, derr_cnt, err, err_code}); else pass_cnt++;
    total_cnt++; if (idle !== 1'b1) $display("FAIL reset_idle got %0b want 1", idle); else pass_cnt++;
    drive_a(3'd4, 8'd1); step(); bus_idle();
    total_cnt++; if (outstanding !== 3'd1) $display("FAIL pre_mid_reset_outst got %0d want 1", outstanding); else pass_cnt++;
    do_reset();
    total_cnt++; if (outstanding !== 3'd0 || err !== 1'b0 || idle !== 1'b1)
      $display("FAIL mid_reset got outst=%0d err=%0b idle=%0b want 0 0 1", outstanding, err, idle); else pass_cnt++;
  endtask

  task automatic test_basic();
    do_reset();
    drive_a(3'd4, 8'd3); step(); bus_idle();
    total_cnt++; if (outstanding !== 3'd1 || get_cnt !== 3'd1 || idle !== 1'b0)
      $display("FAIL basic_alloc got outst=%0d get=%0d idle=%0b want 1 1 0", outstanding, get_cnt, idle); else pass_cnt++;
    step(); step();
    total_cnt++; if (outstanding !== 3'd1) $display("FAIL basic_hold got %0d want 1", outstanding); else pass_cnt++;
    drive_d(3'd1, 8'd3, 1'b0); step(); bus_idle();
    total_cnt++; if (outstanding !== 3'd0 || idle !== 1'b1 || err !== 1'b0 || get_cnt !== 3'd1)
      $display("FAIL basic_free got outst=%0d idle=%0b err=%0b get=%0d want 0 1 0 1", outstanding, idle, err, get_cnt); else pass_cnt++;
  endtask

  task automatic test_overflow();
    do_reset();
    for (int s = 0; s < 5; s++) begin
      drive_a(3'd0, SW'(s)); step();
      if (s == 3) begin
        total_cnt++; if (err !== 1'b0 || outstanding !== 3'd4)
          $display("FAIL ovf_full got err=%0b outst=%0d want 0 4", err, outstanding); else pass_cnt++;
      end
    end
    bus_idle();
    total_cnt++; if (err !== 1'b1 || err_code !== 3'd3)
      $display("FAIL ovf_code got err=%0b code=%0d want 1 3", err, err_code); else pass_cnt++;
    total_cnt++; if (outstanding !== 3'd4 || put_cnt !== 3'd4)
      $display("FAIL ovf_counts got outst=%0d put=%0d want 4 4", outstanding, put_cnt); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int s = 0; s < 4; s++) begin drive_a(3'd0, SW'(s)); step(); end
    drive_a(3'd0, 8'd0); drive_d(3'd0, 8'd0, 1'b0); step(); bus_idle();
    total_cnt++; if (err !== 1'b0 || outstanding !== 3'd4 || put_cnt !== 3'd5)
      $display("FAIL b2b_swap got err=%0b outst=%0d put=%0d want 0 4 5", err, outstanding, put_cnt); else pass_cnt++;
  endtask

  task automatic test_dup_rspop();
    do_reset();
    drive_a(3'd4, 8'd5); step(); step(); bus_idle();
    total_cnt++; if (err !== 1'b1 || err_code !== 3'd2 || outstanding !== 3'd1 || get_cnt !== 3'd1)
      $display("FAIL dup got err=%0b code=%0d outst=%0d get=%0d want 1 2 1 1", err, err_code, outstanding, get_cnt); else pass_cnt++;
    do_reset();
    drive_a(3'd4, 8'd4); step(); bus_idle();
    drive_d(3'd0, 8'd4, 1'b0); step(); bus_idle();
    total_cnt++; if (err_code !== 3'd5 || outstanding !== 3'd0)
      $display("FAIL rspop got code=%0d outst=%0d want 5 0", err_code, outstanding); else pass_cnt++;
  endtask

  task automatic test_unstable();
    do_reset();
    tl.a_valid_i = 1; tl.a_ready_i = 0; tl.a_opcode_i = 3'd4; tl.a_source_i = 8'd1;
    tl.a_address_i = 32'h100; step();
    total_cnt++; if (err !== 1'b0) $display("FAIL unstable_pre got %0b want 0", err); else pass_cnt++;
    tl.a_address_i = 32'h104; step();
    total_cnt++; if (err !== 1'b1 || err_code !== 3'd6)
      $display("FAIL unstable got err=%0b code=%0d want 1 6", err, err_code); else pass_cnt++;
    bus_idle(); drive_d(3'd1, 8'd9, 1'b0); step(); bus_idle();
    total_cnt++; if (err_code !== 3'd6) $display("FAIL unstable_first got %0d want 6", err_code); else pass_cnt++;
  endtask

  task automatic test_timeout();
    do_reset();
    drive_a(3'd4, 8'd7); step(); bus_idle();
    repeat (7) step();
    total_cnt++; if (err !== 1'b0) $display("FAIL tmo_early got %0b want 0", err); else pass_cnt++;
    step();
    total_cnt++; if (err !== 1'b1 || err_code !== 3'd7 || outstanding !== 3'd1)
      $display("FAIL tmo got err=%0b code=%0d outst=%0d want 1 7 1", err, err_code, outstanding); else pass_cnt++;
    drive_d(3'd1, 8'd7, 1'b0); step(); bus_idle();
    total_cnt++; if (outstanding !== 3'd0 || err_code !== 3'd7)
      $display("FAIL tmo_late got outst=%0d code=%0d want 0 7", outstanding, err_code); else pass_cnt++;
  endtask

  task automatic test_multi_err();
    do_reset();
    drive_a(3'd2, 8'd5); drive_d(3'd1, 8'd9, 1'b1); step(); bus_idle();
    total_cnt++; if (err_code !== 3'd1 || derr_cnt !== 3'd1)
      $display("FAIL multi got code=%0d derr=%0d want 1 1", err_code, derr_cnt); else pass_cnt++;
    total_cnt++; if (outstanding !== 3'd0 || get_cnt !== 3'd0 || put_cnt !== 3'd0)
      $display("FAIL multi_noalloc got outst=%0d get=%0d put=%0d want 0 0 0", outstanding, get_cnt, put_cnt); else pass_cnt++;
  endtask

  task automatic test_saturate();
    do_reset();
    for (int n = 0; n < 9; n++) begin
      drive_a(3'd4, 8'd2); step(); bus_idle();
      drive_d(3'd1, 8'd2, 1'b1); step(); bus_idle();
    end
    total_cnt++; if (get_cnt !== 3'd7 || derr_cnt !== 3'd7 || err !== 1'b0)
      $display("FAIL saturate got get=%0d derr=%0d err=%0b want 7 7 0", get_cnt, derr_cnt, err); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_back_to_back();
    test_dup_rspop();
    test_unstable();
    test_timeout();
    test_multi_err();
    test_saturate();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
